// File: rtl/rr_arbiter_register.sv
// rr_arbiter_register
//   Round-robin arbiter that merges NUM valid/ready streams into one
//   registered valid/ready output. The output stage is a single-entry
//   register that can take a new beat on the same cycle the old one drains,
//   which allows one beat per cycle.
//
//   Optional feature: define RR_ARB_LOCK_EN to hold the grant on one
//   requester until it sends a beat with m_last=1, which arbitrates per
//   packet. Without the macro, m_last is ignored and s_last is 0.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   m_valid  in   [NUM]        per-requester valid
//   m_ready  out  [NUM]        per-requester ready, one-hot or zero
//   m_data   in   [NUM*WIDTH]  requester i at [i*WIDTH +: WIDTH]
//   m_last   in   [NUM]        per-requester end-of-packet (lock build only)
//   s_valid  out               registered output valid
//   s_ready  in                downstream ready
//   s_data   out  [WIDTH]      registered output data
//   s_id     out  [IDW]        source requester of s_data
//   s_last   out               registered last flag
//
// Lock FSM (RR_ARB_LOCK_EN)
//   state     | meaning
//   ST_IDLE   | arbitrate round-robin from ptr
//   ST_LOCKED | grant only lock_id until it sends m_last=1

module rr_arbiter_register #(
    parameter int  NUM   = 4,
    parameter int  WIDTH = 8,
    localparam int IDW   = $clog2(NUM)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM-1:0]       m_valid,
    output logic [NUM-1:0]       m_ready,
    input  logic [NUM*WIDTH-1:0] m_data,
    input  logic [NUM-1:0]       m_last,
    output logic                 s_valid,
    input  logic                 s_ready,
    output logic [WIDTH-1:0]     s_data,
    output logic [IDW-1:0]       s_id,
    output logic                 s_last
);

    logic             load;
    logic             found;
    logic [IDW-1:0]   gnt;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   ptr_next;
    logic [WIDTH-1:0] sel_data;
    logic             sel_last;
    logic             adv_ptr;
    int               idx;

`ifdef RR_ARB_LOCK_EN
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]     lock_state;
    logic [IDW-1:0] lock_id;
`else
    logic unused_last;
    assign unused_last = ^m_last;
`endif

    assign load = s_ready | ~s_valid;

    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = 0;
`ifdef RR_ARB_LOCK_EN
        if (lock_state == ST_LOCKED) begin
            // Only the locked requester may proceed, even while it is idle.
            if (m_valid[lock_id]) begin
                found = 1'b1;
                gnt   = lock_id;
            end
        end else begin
`endif
            // Scan ptr, ptr+1, ... with wrap; first valid wins.
            for (int k = 0; k < NUM; k++) begin
                idx = int'(ptr) + k;
                if (idx >= NUM) idx = idx - NUM;
                if (!found && m_valid[idx]) begin
                    found = 1'b1;
                    gnt   = IDW'(idx);
                end
            end
`ifdef RR_ARB_LOCK_EN
        end
`endif
    end

    always_comb begin
        sel_data = m_data[int'(gnt)*WIDTH +: WIDTH];
`ifdef RR_ARB_LOCK_EN
        sel_last = m_last[gnt];
        adv_ptr  = m_last[gnt];
`else
        sel_last = 1'b0;
        adv_ptr  = 1'b1;
`endif
        ptr_next = (gnt == IDW'(NUM - 1)) ? '0 : gnt + 1'b1;
    end

    // Ready is held low during reset so no beat is consumed and then lost.
    always_comb begin
        m_ready = '0;
        for (int i = 0; i < NUM; i++) begin
            m_ready[i] = ~rst & load & found & (gnt == IDW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_valid <= 1'b0;
            s_data  <= '0;
            s_id    <= '0;
            ptr     <= '0;
        end else if (load) begin
            if (found) begin
                s_valid <= 1'b1;
                s_data  <= sel_data;
                s_id    <= gnt;
                if (adv_ptr) ptr <= ptr_next;
            end else begin
                s_valid <= 1'b0;
            end
        end
    end

`ifdef RR_ARB_LOCK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_state <= ST_IDLE;
            lock_id    <= '0;
            s_last     <= 1'b0;
        end else if (load && found) begin
            s_last <= sel_last;
            case (lock_state)
                ST_IDLE: begin
                    if (!sel_last) begin
                        lock_state <= ST_LOCKED;
                        lock_id    <= gnt;
                    end
                end
                default: begin
                    if (sel_last) lock_state <= ST_IDLE;
                end
            endcase
        end
    end
`else
    assign s_last = 1'b0;
`endif

endmodule

// File: doc/rr_arbiter_register.md
# rr_arbiter_register

Round-robin arbiter that shares one valid/ready output channel among `NUM` requesting valid/ready streams and registers the selected beat. The output register is a bubble-free single-stage slice, so each requester sees standard handshake semantics and the downstream port is fully registered. It sits at the convergence point where several producers feed one shared consumer or pipeline.

## Interface
- `NUM`, 4: number of requesters, 2..16.
- `WIDTH`, 8: data width per beat.
- `IDW`, `$clog2(NUM)`: width of `s_id`. Derived; do not override.

- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `m_valid`  in  NUM  per-requester valid.
- `m_ready`  out  NUM  per-requester ready (one-hot or zero).
- `m_data`  in  NUM*WIDTH  requester i occupies bits `[i*WIDTH +: WIDTH]`.
- `m_last`  in  NUM  per-requester end-of-packet flag; used only with the macro.
- `s_valid`  out  1  registered output valid.
- `s_ready`  in  1  downstream ready.
- `s_data`  out  WIDTH  registered output data.
- `s_id`  out  IDW  index of the requester that produced the current `s_data`.
- `s_last`  out  1  registered last flag; constant 0 without the macro.

## Operation
- `load = s_ready | ~s_valid`. The register accepts a new beat, or drains to empty, only when `load=1`.
- Pointer `ptr` (IDW bits) gives the highest-priority requester.
- Grant: the first `i` with `m_valid[i]=1`, scanning `ptr, ptr+1, …, NUM-1, 0, …, ptr-1`.
- `m_ready[i] = load & grant[i]`. All bits are 0 when `load=0` or no requester is valid.
- `m_ready` may depend combinationally on `m_valid` and `s_ready`.
- `s_valid` never depends combinationally on any input.
- When requester `i` handshakes (`m_valid[i] & m_ready[i]`):
  - `s_valid<=1`, `s_data<=m_data[i]`, `s_id<=i`.
  - `ptr <= (i+1) mod NUM` (wrap from `NUM-1` to 0).
- When `load=1` and no requester is valid: `s_valid<=0`. `s_data` and `s_id` hold.
- When `load=0`: `s_valid`, `s_data`, `s_id`, `s_last` and `ptr` all hold.
- Requesters not granted see `m_ready=0` and must hold their beat (standard rule).
- Reset values: `s_valid=0`, `s_data=0`, `s_id=0`, `s_last=0`, `ptr=0` (requester 0 wins first), lock state IDLE.

## Timing
- Latency: 1 cycle from input handshake to `s_valid`/`s_data`.
- Throughput: 1 beat per cycle with no bubbles, including when `s_ready=1` and a new beat is accepted on the same cycle the old one drains.
- Fairness: with all `NUM` requesters continuously valid and `s_ready=1`, grants rotate strictly, and each requester gets one beat every `NUM` cycles.
- Reset mid-operation: the next cycle shows the reset values. A beat held in the register is dropped, and `m_ready` is 0 during the reset cycle.

## Configuration
- Macro `RR_ARB_LOCK_EN`.
- Defined: adds a packet lock with states IDLE and LOCKED, plus a registered `lock_id`.
  - IDLE → LOCKED: on a handshake from requester `i` with `m_last[i]=0`; `lock_id<=i`.
  - In LOCKED, grant is forced to `lock_id` only. Other requesters get `m_ready=0` even while `lock_id` is idle.
  - LOCKED → IDLE: on a handshake from `lock_id` with `m_last=1`.
  - `ptr` updates only on beats with `m_last=1`, so rotation happens per packet.
  - `s_last` is registered together with `s_data`.
  - In IDLE, a single beat with `m_last=1` is a one-beat packet and leaves the state IDLE.
- Undefined: `m_last` is ignored, `s_last` is tied to 0, and arbitration happens every beat as described in Operation.

## Test plan
- Reset: hold `rst=1` with all `m_valid=1`. Expect `m_ready=0000`, `s_valid=0`, `s_data=0`, `s_id=0`. Release `rst` with `s_ready=1`: the first beat is from requester 0.
- Full contention: all 4 valid, each requester sends a constant `8'hA0+i`, `s_ready=1`. Expect `s_id` sequence 0,1,2,3,0,… and `s_data` A0,A1,A2,A3,A0, one per cycle, no gaps.
- Backpressure: output holding `s_id=2`, `s_data=8'h55`, then `s_ready=0` for 3 cycles. Expect output stable, `m_ready=0000`. When `s_ready` returns to 1, the next grant goes to 3 if valid.
- Sparse and wrap: only requester 1 valid for one cycle, then only requester 0. Expect grants 1 then 0 on consecutive cycles; `s_valid` falls after the last beat drains.
- Lock (macro on): requester 2 sends 3 beats with last=0,0,1 while requester 0 is valid throughout. Expect `s_id` 2,2,2 with `s_last` 0,0,1, then 0.
- Reset mid-packet (macro on): assert `rst` after the first beat of a locked packet. Expect state IDLE, `s_valid=0`, `ptr=0`, and requester 0 granted first after release.
